// File: rtl/multipack_shift_chain.sv
// ---------------------------------------------------------------------------
// multipack_shift_chain
//
// Purpose:
//   A chain of LANES registers, each WIDTH bits wide. The lanes are shifted
//   together as one N = LANES*WIDTH bit serial register. Bits cross lane
//   boundaries with no gap. The chain serves as a pattern generator
//   (TOGGLE / ROTATE / JOHNSON feeds) and as a deserialiser (FEED mode)
//   in front of multi-lane datapaths.
//
//   Flat bit k = i*WIDTH + j is presented as data[i][j].
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset (highest priority)
//   enable       in   perform one shift this cycle
//   dir          in   0 = left (toward higher flat index), 1 = right
//   mode         in   feed source: 0 FEED, 1 TOGGLE, 2 ROTATE, 3 JOHNSON
//   serial_in    in   external feed bit, used in FEED mode
//   load         in   parallel write of one lane (wins over enable)
//   load_lane    in   lane index for load; out-of-range means no change
//   load_data    in   value written on load
//   data         out  unpacked array of lane registers
//   serial_out   out  exit bit: flat[N-1] when dir=0, flat[0] when dir=1
//   shift_count  out  shifts performed, modulo N
//   wrap         out  one-cycle pulse after shift_count wraps to 0
// ---------------------------------------------------------------------------
module multipack_shift_chain #(
  parameter  int LANES = 5,
  parameter  int WIDTH = 11,
  localparam int N     = LANES * WIDTH,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic             load,
  input  logic [CW-1:0]    load_lane,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data [LANES],
  output logic             serial_out,
  output logic [CW-1:0]    shift_count,
  output logic             wrap
);

  localparam logic [1:0] MODE_FEED    = 2'd0;
  localparam logic [1:0] MODE_TOGGLE  = 2'd1;
  localparam logic [1:0] MODE_ROTATE  = 2'd2;
  localparam logic [1:0] MODE_JOHNSON = 2'd3;

  localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [N-1:0]  r_flat;
  logic [CW-1:0] r_count;
  logic          r_wrap;

  // ---------------------------------------------------------------------
  // Feed selection and shifted images
  // ---------------------------------------------------------------------
  logic          w_exit;
  logic          w_entry;
  logic          w_feed;
  logic [N-1:0]  w_shift_left;
  logic [N-1:0]  w_shift_right;
  logic [N-1:0]  w_shift_next;

  always_comb begin
    // The exit bit leaves the chain on this shift. The entry bit sits in
    // the position that the feed overwrites. Both use pre-shift values.
    w_exit  = dir ? r_flat[0]   : r_flat[N-1];
    w_entry = dir ? r_flat[N-1] : r_flat[0];

    w_feed = serial_in;
    case (mode)
      MODE_FEED:    w_feed = serial_in;
      MODE_TOGGLE:  w_feed = ~w_entry;
      MODE_ROTATE:  w_feed = w_exit;
      MODE_JOHNSON: w_feed = ~w_exit;
      default:      w_feed = serial_in;
    endcase

    // A whole-vector shift followed by a single-bit overwrite also covers
    // N == 1. That case has no k-1 neighbour to slice.
    w_shift_left     = r_flat << 1;
    w_shift_left[0]  = w_feed;
    w_shift_right    = r_flat >> 1;
    w_shift_right[N-1] = w_feed;

    w_shift_next = dir ? w_shift_right : w_shift_left;
  end

  // ---------------------------------------------------------------------
  // Lane load: one-hot lane select; an out-of-range index selects nothing.
  // ---------------------------------------------------------------------
  logic [LANES-1:0] w_lane_sel;
  logic [N-1:0]     w_load_next;
  logic             w_load_valid;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_sel[gi] = (load_lane == CW'(gi));
      assign w_load_next[gi*WIDTH +: WIDTH] =
        w_lane_sel[gi] ? load_data : r_flat[gi*WIDTH +: WIDTH];
      assign data[gi] = r_flat[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_load_valid = |w_lane_sel;

  // ---------------------------------------------------------------------
  // Shift counter
  // ---------------------------------------------------------------------
  logic          w_count_at_last;
  logic [CW-1:0] w_count_next;

  assign w_count_at_last = (r_count == COUNT_LAST);
  assign w_count_next    = w_count_at_last ? '0 : (r_count + 1'b1);

  // ---------------------------------------------------------------------
  // Sequential update: reset > load > enable > hold
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_flat  <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      // A load suppresses any shift requested in the same cycle. An
      // invalid lane index leaves the data untouched. wrap only marks
      // shift cycles, so it drops here.
      if (w_load_valid) begin
        r_flat <= w_load_next;
      end
      r_wrap <= 1'b0;
    end else if (enable) begin
      r_flat  <= w_shift_next;
      r_count <= w_count_next;
      r_wrap  <= w_count_at_last;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign serial_out  = dir ? r_flat[0] : r_flat[N-1];
  assign shift_count = r_count;
  assign wrap        = r_wrap;

endmodule

// File: tb/tb_multipack_shift_chain.sv
// ---------------------------------------------------------------------------
// tb_multipack_shift_chain
//
// Directed bench for multipack_shift_chain with LANES=5 and WIDTH=11.
// Each step does three things:
//   - drives one cycle of inputs on the falling edge;
//   - pushes the expected post-edge state from a behavioural model onto a
//     scoreboard queue;
//   - at the next falling edge, pops that entry and compares it against
//     the DUT outputs.
// Directed constant checks mirror the scenarios of the test plan.
// ---------------------------------------------------------------------------
module tb_multipack_shift_chain;

  localparam int LANES = 5;
  localparam int WIDTH = 11;
  localparam int N     = LANES * WIDTH;
  localparam int CW    = 6;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             dir;
  logic [1:0]       mode;
  logic             serial_in;
  logic             load;
  logic [CW-1:0]    load_lane;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] data [LANES];
  logic             serial_out;
  logic [CW-1:0]    shift_count;
  logic             wrap;

  multipack_shift_chain #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .dir        (dir),
    .mode       (mode),
    .serial_in  (serial_in),
    .load       (load),
    .load_lane  (load_lane),
    .load_data  (load_data),
    .data       (data),
    .serial_out (serial_out),
    .shift_count(shift_count),
    .wrap       (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] flat;
    int           cnt;
    logic         wrap;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [N-1:0] m_flat;
  int           m_cnt;
  logic         m_wrap;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [N-1:0] flat);
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("%s lane%0d", tag, i), 64'(data[i]),
            64'(flat[i*WIDTH +: WIDTH]));
    end
  endtask

  // One cycle: drive, model, push; then wait one edge, pop, compare.
  task automatic step(input string tag, input logic rst, input logic ld,
                      input int lane, input logic [WIDTH-1:0] ld_data,
                      input logic en, input logic d, input logic [1:0] m,
                      input logic si);
    exp_t e;
    logic fb;
    logic ex;
    logic [N-1:0] nf;
    reset     = rst;
    load      = ld;
    load_lane = CW'(lane);
    load_data = ld_data;
    enable    = en;
    dir       = d;
    mode      = m;
    serial_in = si;

    if (rst) begin
      m_flat = '0;
      m_cnt  = 0;
      m_wrap = 1'b0;
    end else if (ld) begin
      if (lane < LANES) m_flat[lane*WIDTH +: WIDTH] = ld_data;
      m_wrap = 1'b0;
    end else if (en) begin
      ex = d ? m_flat[0] : m_flat[N-1];
      case (m)
        2'd0: fb = si;
        2'd1: fb = d ? ~m_flat[N-1] : ~m_flat[0];
        2'd2: fb = ex;
        default: fb = ~ex;
      endcase
      for (int k = 0; k < N; k++) begin
        if (d == 1'b0) nf[k] = (k == 0)     ? fb : m_flat[k-1];
        else           nf[k] = (k == N - 1) ? fb : m_flat[k+1];
      end
      m_flat = nf;
      m_wrap = (m_cnt == N - 1);
      m_cnt  = (m_cnt == N - 1) ? 0 : m_cnt + 1;
    end else begin
      m_wrap = 1'b0;
    end

    e.flat = m_flat;
    e.cnt  = m_cnt;
    e.wrap = m_wrap;
    sb.push_back(e);

    @(negedge clock);

    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check_lanes(tag, e.flat);
      check({tag, " count"}, 64'(shift_count), 64'(e.cnt));
      check({tag, " wrap"}, 64'(wrap), 64'(e.wrap));
      check({tag, " sout"}, 64'(serial_out),
            64'(dir ? e.flat[0] : e.flat[N-1]));
    end
    $display("step %-10s rst=%0b ld=%0b lane=%0d en=%0b dir=%0b mode=%0d si=%0b -> cnt=%0d wrap=%0b sout=%0b",
             tag, rst, ld, lane, en, d, m, si, shift_count, wrap, serial_out);
  endtask

  int wraps;

  initial begin
    reset = 1'b0; enable = 1'b0; dir = 1'b0; mode = 2'd0;
    serial_in = 1'b0; load = 1'b0; load_lane = '0; load_data = '0;
    m_flat = '0; m_cnt = 0; m_wrap = 1'b0;

    @(negedge clock);

    // Reset state
    step("reset", 1, 0, 0, 11'h0, 0, 0, 2'd0, 0);
    check("reset cnt0", 64'(shift_count), 64'd0);

    // 1. Toggle chain
    step("tog1", 0, 0, 0, 11'h0, 1, 0, 2'd1, 0);
    check("tog1 d0", 64'(data[0]), 64'h001);
    step("tog2", 0, 0, 0, 11'h0, 1, 0, 2'd1, 0);
    check("tog2 d0", 64'(data[0]), 64'h002);
    step("tog3", 0, 0, 0, 11'h0, 1, 0, 2'd1, 0);
    check("tog3 d0", 64'(data[0]), 64'h005);
    check("tog3 d1", 64'(data[1]), 64'h000);
    check("tog3 cnt", 64'(shift_count), 64'd3);

    // 2. Cross-lane carry, left then right
    step("rst2", 1, 0, 0, 11'h0, 0, 0, 2'd0, 0);
    step("ld0", 0, 1, 0, 11'h400, 0, 0, 2'd0, 0);
    step("carryL", 0, 0, 0, 11'h0, 1, 0, 2'd0, 0);
    check("carryL d0", 64'(data[0]), 64'h000);
    check("carryL d1", 64'(data[1]), 64'h001);
    step("carryR", 0, 0, 0, 11'h0, 1, 1, 2'd0, 0);
    check("carryR d0", 64'(data[0]), 64'h400);
    check("carryR d1", 64'(data[1]), 64'h000);

    // 3. Rotate
    step("rst3", 1, 0, 0, 11'h0, 0, 0, 2'd0, 0);
    step("ld4", 0, 1, 4, 11'h400, 0, 0, 2'd2, 0);
    check("rot pre sout", 64'(serial_out), 64'd1);
    step("rot", 0, 0, 0, 11'h0, 1, 0, 2'd2, 0);
    check("rot d0", 64'(data[0]), 64'h001);
    check("rot d4", 64'(data[4]), 64'h000);
    check("rot sout", 64'(serial_out), 64'd0);

    // 4. Johnson and wrap
    step("rst4", 1, 0, 0, 11'h0, 0, 0, 2'd0, 0);
    wraps = 0;
    for (int s = 1; s <= 110; s++) begin
      step($sformatf("john%0d", s), 0, 0, 0, 11'h0, 1, 1, 2'd3, 0);
      if (wrap) wraps++;
      if (s == 55) begin
        for (int i = 0; i < LANES; i++)
          check($sformatf("john55 lane%0d", i), 64'(data[i]), 64'h7FF);
        check("john55 cnt", 64'(shift_count), 64'd0);
        check("john55 wraps", 64'(wraps), 64'd1);
      end
    end
    for (int i = 0; i < LANES; i++)
      check($sformatf("john110 lane%0d", i), 64'(data[i]), 64'h000);
    check("john110 wraps", 64'(wraps), 64'd2);
    step("john111", 0, 0, 0, 11'h0, 1, 1, 2'd3, 0);
    check("john111 nowrap", 64'(wrap), 64'd0);

    // 5. Priority
    step("pre5", 0, 0, 0, 11'h0, 1, 0, 2'd1, 0);
    step("ldEn", 0, 1, 2, 11'h155, 1, 0, 2'd1, 0);
    check("ldEn d2", 64'(data[2]), 64'h155);
    check("ldEn cnt", 64'(shift_count), 64'd2);
    step("ldBad", 0, 1, 5, 11'h3AA, 1, 0, 2'd1, 0);
    check("ldBad d2", 64'(data[2]), 64'h155);
    check("ldBad cnt", 64'(shift_count), 64'd2);
    step("rstAll", 1, 1, 1, 11'h7FF, 1, 0, 2'd1, 1);
    for (int i = 0; i < LANES; i++)
      check($sformatf("rstAll lane%0d", i), 64'(data[i]), 64'h000);
    check("rstAll cnt", 64'(shift_count), 64'd0);

    // 6. Hold
    step("ldH", 0, 1, 3, 11'h2C3, 0, 0, 2'd0, 0);
    step("shH", 0, 0, 0, 11'h0, 1, 0, 2'd0, 1);
    for (int h = 0; h < 10; h++) begin
      step($sformatf("hold%0d", h), 0, 0, 0, 11'h0, 0, 0, 2'd0, h[0]);
    end
    check("hold cnt", 64'(shift_count), 64'd1);
    check("hold d0", 64'(data[0]), 64'h001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multipack_shift_chain.md
Name: multipack_shift_chain

Overview:
- Parametrised chain of LANES packed registers, each WIDTH bits wide, shifted as one LANES*WIDTH-bit serial register.
- Presents its state on an unpacked-array output port and carries bits across lane boundaries.
- Generalises the fixed 5x11 left-shift toggle chain with:
  - configurable geometry and direction;
  - four feed modes;
  - parallel lane load and clock enable;
  - a shift counter with a wrap pulse.
- Used as a pattern generator and deserialiser feeding multi-lane datapaths.

Parameters:
- LANES, 5, number of lanes (>=1).
- WIDTH, 11, bits per lane (>=1).
- Derived (not overridable): N = LANES*WIDTH; CW = max(1, $clog2(N)).

Ports:
- clock  input  1  rising-edge clock; all state updates on posedge only.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  perform one shift this cycle.
- dir  input  1  0 = left (toward higher flat index), 1 = right.
- mode  input  2  feed source: 0 FEED, 1 TOGGLE, 2 ROTATE, 3 JOHNSON.
- serial_in  input  1  external feed bit, used in FEED mode.
- load  input  1  parallel write of one lane this cycle.
- load_lane  input  CW  lane index for load.
- load_data  input  WIDTH  value written on load.
- data  output  [WIDTH-1:0] x [LANES]  unpacked array of lane registers.
- serial_out  output  1  exit bit: flat bit N-1 when dir=0, flat bit 0 when dir=1; combinational from registers.
- shift_count  output  CW  shifts performed, mod N.
- wrap  output  1  one-cycle pulse after shift_count wraps.

Behaviour:
- Flat index: k = i*WIDTH + j maps to data[i][j].
- Reset (sync, highest priority): all data lanes 0, shift_count 0, wrap 0. Reset mid-shift discards the operation.
- Priority: reset > load > enable.
  - load and enable in the same cycle: only the load occurs; shift_count and wrap unaffected.
- Load: data[load_lane] <= load_data; all other lanes hold.
  - load_lane >= LANES: no state changes at all.
- Shift (enable=1, load=0), dir=0:
  - flat[k+1] <= flat[k] for k in 0..N-2;
  - flat[0] <= feed.
- Shift, dir=1:
  - flat[k] <= flat[k+1];
  - flat[N-1] <= feed.
- feed uses pre-shift values and the exit bit e (flat[N-1] when dir=0, flat[0] when dir=1):
  - FEED: serial_in.
  - TOGGLE: ~(entry bit), where the entry bit is flat[0] when dir=0 and flat[N-1] when dir=1.
  - ROTATE: e.
  - JOHNSON: ~e.
- Lane boundaries are transparent. Left: data[i][0] <= data[i-1][WIDTH-1]. Right: mirrored.
- Counter, on each performed shift:
  - if shift_count == N-1: shift_count <= 0 and wrap <= 1;
  - else: shift_count + 1 and wrap <= 0.
- wrap is 0 in any cycle without a shift.
- enable=0 and load=0: all state holds; wrap <= 0.
- mode and dir may change every cycle; each shift uses the values sampled in its own cycle.
- LANES=1 or WIDTH=1 must elaborate and behave per the flat-index rules.
- Latency: data, shift_count and wrap update one clock after the sampled request; serial_out follows data with no added delay.

Test Plan (LANES=5, WIDTH=11, N=55):
1. Toggle chain: reset, then mode=1, dir=0, enable for 3 cycles.
   - data[0] steps 11'h001, 11'h002, 11'h005; other lanes 0; shift_count=3.
2. Cross-lane carry: load lane 0 with 11'h400, then FEED, serial_in=0, dir=0, one shift.
   - data[0]=0, data[1]=11'h001.
   - Repeat with dir=1 from data[1]=11'h001: data[0]=11'h400.
3. Rotate: load lane 4 with 11'h400; serial_out=1 before shift; mode=2, dir=0, one shift.
   - data[0]=11'h001, data[4]=0, serial_out=0.
4. Johnson/wrap: from reset, mode=3, dir=1, enable held.
   - After 55 shifts: all lanes 11'h7FF, shift_count=0, wrap high exactly one cycle.
   - After 110 shifts: all lanes 0, second wrap pulse.
5. Priority:
   - load=1, load_lane=2, load_data=11'h155 with enable=1: data[2]=11'h155, no shift, shift_count unchanged.
   - load_lane=5: no change.
   - reset asserted alongside enable and load: all outputs 0 next cycle.
6. Hold/clock-enable: enable=0 for 10 cycles with serial_in toggling.
   - data, shift_count unchanged; wrap stays 0.
